dmem_responder: RTL and testbench

- Data-memory responder: the target end of the core's load/store request interface.
- Accepts one request at a time over a valid/ready request channel and performs byte, half or word access to a byte-addressed array at BASE_ADDR.
- Returns load data, sign- or zero-extended per funct3, over a valid/ready response channel after a fixed LATENCY.
- Replaces the combinational dmem so the memory stage can be made multi-cycle in the pipelined core.

---
 rtl/mem_pkg.sv | 45 ++++
 rtl/dmem_byte_array.sv | 27 ++
 rtl/dmem_responder.sv | 195 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder: access sizes,
// responder FSM states and the load-data extension rule.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } rsp_state_e;

  localparam int WORD_BYTES = 4;

  // Number of bytes touched by an access; 0 marks the illegal encoding.
  function automatic logic [2:0] size_bytes(input mem_size_e size);
    case (size)
      MEM_B:   return 3'd1;
      MEM_H:   return 3'd2;
      MEM_W:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Pick the addressed lane(s) out of a little-endian word and extend to 32 bits.
  function automatic logic [31:0] ld_extend(input logic [31:0] word,
                                            input mem_size_e   size,
                                            input logic        is_unsigned,
                                            input logic [1:0]  byte_off);
    logic [31:0] shifted;
    shifted = word >> {byte_off, 3'b000};
    case (size)
      MEM_B:   return is_unsigned ? {24'd0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      MEM_H:   return is_unsigned ? {16'd0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-addressed storage organised as 32-bit words with four byte write lanes
// and a combinational little-endian read port.
module dmem_byte_array #(
  parameter  int DEPTH = 4096,
  localparam int WA_W  = $clog2(DEPTH / 4)
) (
  input  logic            clk,
  input  logic [3:0]      we,
  input  logic [WA_W-1:0] waddr,
  input  logic [31:0]     wdata,
  input  logic [WA_W-1:0] raddr,
  output logic [31:0]     rdata
);

  logic [3:0][7:0] mem [DEPTH / 4];

  // NOTE: the storage array has no reset branch; clearing a RAM on reset is not
  // implementable in block memory and its contents must survive a core reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][i] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target end of the core's load/store request channel,
// answering each accepted request over a valid/ready response after LATENCY cycles.
`ifndef MEM_DEPTH
`define MEM_DEPTH 4096
`endif

module dmem_responder
  import mem_pkg::*;
#(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h0200_0000),
  parameter int                DEPTH     = `MEM_DEPTH,
  parameter int                LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int OFF_W = $clog2(DEPTH);
  localparam int CNT_W = 4;

  rsp_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q;
  logic             accept;
  logic             enter_resp;

  mem_size_e         in_size;
  logic [AWIDTH-1:0] in_off;
  logic [AWIDTH:0]   in_end;
  logic              in_fault;

  logic [OFF_W-1:0]  off_q;
  mem_size_e         size_q;
  logic              uns_q;
  logic              we_q;
  logic              fault_q;

  logic [OFF_W-1:0]  cur_off;
  mem_size_e         cur_size;
  logic              cur_uns;
  logic              cur_we;
  logic              cur_fault;

  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic [31:0]       rd_word;
  logic [31:0]       load_val;
  logic [DWIDTH-1:0] rdata_q;
  logic              err_q;

  // Request decode: offset into the array and every fault condition.
  assign in_size = mem_size_e'(req_size_i);
  assign in_off  = req_addr_i - BASE_ADDR;
  assign in_end  = {1'b0, in_off} + (AWIDTH+1)'(size_bytes(in_size));

  assign in_fault = (req_size_i == 2'd3)
                 || (req_addr_i < BASE_ADDR)
                 || (in_off >= AWIDTH'(DEPTH))
                 || (in_end > (AWIDTH+1)'(DEPTH))
                 || ((in_size == MEM_H) && in_off[0])
                 || ((in_size == MEM_W) && (in_off[1:0] != 2'b00));

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i && ready_q) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  // Stores commit on the acceptance edge; lanes are replicated so the
  // byte-enable alone selects where the data lands.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = req_wdata_i[31:0];
    case (in_size)
      MEM_B: begin
        wr_be   = 4'b0001 << in_off[1:0];
        wr_data = {4{req_wdata_i[7:0]}};
      end
      MEM_H: begin
        wr_be   = 4'b0011 << in_off[1:0];
        wr_data = {2{req_wdata_i[15:0]}};
      end
      MEM_W:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
    if (!(accept && req_we_i && !in_fault)) wr_be = 4'b0000;
  end

  // With LATENCY=1 the response is formed on the acceptance edge itself, so the
  // read side takes the live request instead of the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      cur_off   = in_off[OFF_W-1:0];
      cur_size  = in_size;
      cur_uns   = req_unsigned_i;
      cur_we    = req_we_i;
      cur_fault = in_fault;
    end else begin
      cur_off   = off_q;
      cur_size  = size_q;
      cur_uns   = uns_q;
      cur_we    = we_q;
      cur_fault = fault_q;
    end
  end

  dmem_byte_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (wr_be),
    .waddr (in_off[OFF_W-1:2]),
    .wdata (wr_data),
    .raddr (cur_off[OFF_W-1:2]),
    .rdata (rd_word)
  );

  assign load_val = (cur_fault || cur_we) ? 32'd0
                  : ld_extend(rd_word, cur_size, cur_uns, cur_off[1:0]);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == IDLE);
      if (enter_resp) begin
        rdata_q <= load_val;
        err_q   <= cur_fault;
      end
    end
  end

  // Request fields are only consumed while a transaction is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      off_q   <= in_off[OFF_W-1:0];
      size_q  <= in_size;
      uns_q   <= req_unsigned_i;
      we_q    <= req_we_i;
      fault_q <= in_fault;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a byte-array reference model scored
// against the DUT every cycle, plus hand-computed expectations.
module tb_dmem_responder;

  localparam int          DEPTH   = 256;
  localparam int          LATENCY = 2;
  localparam logic [31:0] BASE    = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  dmem_responder #(
    .AWIDTH    (32),
    .DWIDTH    (32),
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH),
    .LATENCY   (LATENCY)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a plain byte array plus the transaction in flight.
  byte unsigned mem_m [DEPTH];
  bit           busy_m, valid_m, ready_m, live_m;
  int           since_m, acc_cnt;
  bit           exp_err;
  logic [31:0]  exp_rdata;
  logic [31:0]  got_rdata;
  logic         got_err;

  function automatic void model_access(input logic [31:0] a, input logic [31:0] wd,
                                       input bit we, input logic [1:0] sz, input bit uns,
                                       output bit err, output logic [31:0] rd);
    longint off = longint'(a) - longint'(BASE);
    int     nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    longint val = 0;
    rd = 32'd0;
    if (nb == 0) err = 1'b1;
    else err = (off < 0) || (off + nb > DEPTH) || ((a % nb) != 0);
    if (!err) begin
      for (int k = 0; k < nb; k++) begin
        if (we) mem_m[off+k] = wd[8*k +: 8];
        else    val = val | (longint'(mem_m[off+k]) << (8*k));
      end
      if (!we) begin
        if (!uns && nb < 4 && val[8*nb-1]) val = val - (longint'(1) << (8*nb));
        rd = val[31:0];
      end
    end
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      busy_m  = 1'b0;
      valid_m = 1'b0;
      ready_m = 1'b0;
      live_m  = 1'b1;
    end else begin
      if (busy_m) begin
        if (valid_m && rsp_ready_i) busy_m = 1'b0;
        else since_m++;
      end else if (ready_m && req_valid_i) begin
        model_access(req_addr_i, req_wdata_i, req_we_i, req_size_i, req_unsigned_i,
                     exp_err, exp_rdata);
        busy_m  = 1'b1;
        since_m = 1;
        acc_cnt++;
      end
      valid_m = busy_m && (since_m >= LATENCY);
      ready_m = !busy_m;
    end
  end

  initial forever begin
    @(negedge clk);
    if (live_m) begin
      check("req_ready", 32'(req_ready_o), 32'(ready_m));
      check("rsp_valid", 32'(rsp_valid_o), 32'(valid_m));
      if (valid_m) begin
        check("rsp_err", 32'(rsp_err_o), 32'(exp_err));
        check("rsp_rdata", rsp_rdata_o, exp_rdata);
      end
      if (rsp_valid_o && rsp_ready_i) begin
        got_rdata = rsp_rdata_o;
        got_err   = rsp_err_o;
      end
    end
  end

  // Junk on the request channel while the responder is busy must be ignored.
  task automatic scramble();
    req_valid_i    = 1'($urandom);
    req_addr_i     = BASE + 32'($urandom_range(0, DEPTH-1));
    req_wdata_i    = $urandom;
    req_we_i       = 1'($urandom);
    req_size_i     = 2'($urandom);
    req_unsigned_i = 1'($urandom);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] wd, input bit we,
                      input logic [1:0] sz, input bit uns, input int hold, output int lat);
    int n0 = acc_cnt;
    int t  = 0;
    req_valid_i    = 1'b1;
    req_addr_i     = a;
    req_wdata_i    = wd;
    req_we_i       = we;
    req_size_i     = sz;
    req_unsigned_i = uns;
    rsp_ready_i    = (hold == 0);
    lat = 0;
    while (acc_cnt == n0 && t < 40) begin
      @(posedge clk); #2;
      t++;
    end
    check("accept_seen", 32'(acc_cnt != n0), 32'd1);
    if (acc_cnt == n0) begin
      req_valid_i = 1'b0;
      return;
    end
    lat = 1;
    scramble();
    while (rsp_valid_o !== 1'b1 && lat < 20) begin
      @(posedge clk); #2;
      lat++;
      scramble();
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
      scramble();
    end
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b0;
    @(posedge clk); #2;
    if (hold > 0) check("ready_after_hs", 32'(req_ready_o), 32'd1);
  endtask

  task automatic expect_rsp(input string name, input logic [31:0] rd, input logic err);
    check({name, "_err"}, 32'(got_err), 32'(err));
    check({name, "_rdata"}, got_rdata, rd);
  endtask

  task automatic reset_in_busy(input logic [31:0] a, input logic [31:0] wd, input bit we);
    int n0 = acc_cnt;
    int t  = 0;
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_wdata_i = wd;
    req_we_i    = we;
    req_size_i  = 2'd2;
    rsp_ready_i = 1'b1;
    while (acc_cnt == n0 && t < 40) begin
      @(posedge clk); #2;
      t++;
    end
    check("rst_accept_seen", 32'(acc_cnt != n0), 32'd1);
    req_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    check("rst_mid_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_mid_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk); #2;
    check("rst_mid_ready_after", 32'(req_ready_o), 32'd1);
    repeat (6) @(posedge clk);
    #2;
  endtask

  initial begin
    int lat;
    rst            = 1'b1;
    req_valid_i    = 1'b0;
    req_addr_i     = '0;
    req_wdata_i    = '0;
    req_we_i       = 1'b0;
    req_size_i     = 2'd0;
    req_unsigned_i = 1'b0;
    rsp_ready_i    = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_ready", 32'(req_ready_o), 32'd0);
    check("reset_valid", 32'(rsp_valid_o), 32'd0);
    check("reset_rdata", rsp_rdata_o, 32'd0);
    check("reset_err", 32'(rsp_err_o), 32'd0);
    rst = 1'b0;
    @(posedge clk); #2;
    check("ready_out_of_reset", 32'(req_ready_o), 32'd1);

    for (int w = 0; w < DEPTH/4; w++) send(BASE + 32'(4*w), $urandom, 1'b1, 2'd2, 1'b0, 0, lat);

    send(32'h0200_0010, 32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0, 0, lat);
    check("sw_latency", 32'(lat), 32'd2);
    expect_rsp("sw", 32'd0, 1'b0);
    send(32'h0200_0010, 32'h0, 1'b0, 2'd2, 1'b0, 0, lat);
    expect_rsp("lw", 32'hDEAD_BEEF, 1'b0);
    send(32'h0200_0013, 32'h0, 1'b0, 2'd0, 1'b0, 0, lat);
    expect_rsp("lb", 32'hFFFF_FFDE, 1'b0);
    send(32'h0200_0013, 32'h0, 1'b0, 2'd0, 1'b1, 0, lat);
    expect_rsp("lbu", 32'h0000_00DE, 1'b0);
    send(32'h0200_0010, 32'h0, 1'b0, 2'd1, 1'b0, 0, lat);
    expect_rsp("lh", 32'hFFFF_BEEF, 1'b0);
    send(32'h0200_0011, 32'h1234_565A, 1'b1, 2'd0, 1'b0, 0, lat);
    expect_rsp("sb", 32'd0, 1'b0);
    send(32'h0200_0010, 32'h0, 1'b0, 2'd2, 1'b0, 0, lat);
    expect_rsp("lw_after_sb", 32'hDEAD_5AEF, 1'b0);
    send(32'h0200_0011, 32'h0, 1'b0, 2'd1, 1'b0, 0, lat);
    expect_rsp("lh_misaligned", 32'd0, 1'b1);
    send(32'h01FF_FFFC, 32'h1111_1111, 1'b1, 2'd2, 1'b0, 0, lat);
    expect_rsp("sw_below_base", 32'd0, 1'b1);
    send(32'h0200_0010, 32'h0, 1'b0, 2'd2, 1'b0, 5, lat);
    expect_rsp("lw_held", 32'hDEAD_5AEF, 1'b0);

    send(32'h0200_00FC, 32'hCAFE_F00D, 1'b1, 2'd2, 1'b0, 0, lat);
    expect_rsp("sw_last_word", 32'd0, 1'b0);
    send(32'h0200_00FC, 32'h0, 1'b0, 2'd2, 1'b0, 0, lat);
    expect_rsp("lw_last_word", 32'hCAFE_F00D, 1'b0);
    send(32'h0200_00FE, 32'h0, 1'b0, 2'd1, 1'b1, 0, lat);
    expect_rsp("lhu_top", 32'h0000_CAFE, 1'b0);
    send(32'h0200_00FC, 32'h0, 1'b0, 2'd0, 1'b0, 0, lat);
    expect_rsp("lb_last_word", 32'h0000_000D, 1'b0);
    send(32'h0200_0100, 32'h0, 1'b0, 2'd2, 1'b0, 0, lat);
    expect_rsp("lw_past_end", 32'd0, 1'b1);
    send(32'h0200_00FF, 32'h0, 1'b0, 2'd1, 1'b0, 0, lat);
    expect_rsp("lh_top_misaligned", 32'd0, 1'b1);
    send(32'h0200_0010, 32'h0, 1'b0, 2'd3, 1'b0, 0, lat);
    expect_rsp("illegal_size", 32'd0, 1'b1);

    reset_in_busy(32'h0200_0010, 32'h0, 1'b0);
    reset_in_busy(32'h0200_0020, 32'h0BAD_C0DE, 1'b1);
    send(32'h0200_0020, 32'h0, 1'b0, 2'd2, 1'b0, 0, lat);
    expect_rsp("store_survives_reset", 32'h0BAD_C0DE, 1'b0);

    for (int n = 0; n < 300; n++) begin
      send(BASE + 32'($urandom_range(0, DEPTH+7)) - 32'd4, $urandom, 1'($urandom),
           2'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 3), lat);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
